autocorrelation_accumulator: RTL

// - Datapath stage paired with the autocorrelation sequencer. Consumes sample pairs x[n], x[n+lag] plus lag-boundary strobes.
// - Multiply-accumulates each pair; closes one R[lag] per boundary strobe and stores R[0..ORDER] in a result bank.
// - The downstream Levinson-Durbin stage reads R[0..ORDER] from the bank once done pulses.

---
 rtl/lpc_pkg.sv | 18 +
 rtl/lpc_mac_pipe.sv | 69 ++++++
 rtl/autocorrelation_accumulator.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC autocorrelation datapath.
// Holds the default widths/order used by the accumulator and its MAC pipe,
// and the frame-level FSM state encoding.
package lpc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LAG_W  = 11;
  localparam int DEF_ORDER  = 10;
  localparam int DEF_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/lpc_mac_pipe.sv
// First two stages of the autocorrelation datapath.
// S1 registers the sample pair and its control; S2 registers the signed
// product a*b together with valid/next_lag/lag so S3 sees them aligned.
// Ports:
//   clk, reset          clock, synchronous active-high reset (control only)
//   mac_en, next_lag    pair valid / lag close, already gated by the caller
//   sample_a, sample_b  signed sample pair
//   lag                 lag index of the pair
//   vld_p2, nl_p2       S2 valid / close strobe
//   lag_p2, prod_p2     S2 lag index and 2*DATA_W signed product
module lpc_mac_pipe
  import lpc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAG_W  = DEF_LAG_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mac_en,
  input  logic                       next_lag,
  input  logic signed [DATA_W-1:0]   sample_a,
  input  logic signed [DATA_W-1:0]   sample_b,
  input  logic [LAG_W-1:0]           lag,
  output logic                       vld_p2,
  output logic                       nl_p2,
  output logic [LAG_W-1:0]           lag_p2,
  output logic signed [2*DATA_W-1:0] prod_p2
);

  logic                     vld_p1;
  logic                     nl_p1;
  logic [LAG_W-1:0]         lag_p1;
  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;

  // S1: input registers
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      nl_p1  <= 1'b0;
    end else begin
      vld_p1 <= mac_en;
      nl_p1  <= next_lag;
    end
  end

  always_ff @(posedge clk) begin
    a_p1   <= sample_a;
    b_p1   <= sample_b;
    lag_p1 <= lag;
  end

  // S2: product register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      nl_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      nl_p2  <= nl_p1;
    end
  end

  always_ff @(posedge clk) begin
    prod_p2 <= a_p1 * b_p1;
    lag_p2  <= lag_p1;
  end

endmodule

// File: rtl/autocorrelation_accumulator.sv
// Autocorrelation accumulator: multiply-accumulates x[n]*x[n+lag] pairs,
// closes one saturated R[lag] per next_lag strobe and stores R[0..ORDER] in a
// result bank read by the Levinson-Durbin stage after done pulses.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a frame (IDLE only)
//   mac_en, sample_a/b    sample pair valid and data
//   next_lag, lag         close current lag / lag index of the pair
//   r_valid, r_lag        one-cycle strobe and lag of r_value
//   r_value               completed R value
//   ovf                   sticky saturation flag for this frame
//   busy, done            frame in progress / one-cycle completion pulse
//   rd_addr, rd_data      bank read port, 1-cycle latency
module autocorrelation_accumulator
  import lpc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LAG_W  = DEF_LAG_W,
  parameter int ORDER  = DEF_ORDER,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mac_en,
  input  logic signed [DATA_W-1:0] sample_a,
  input  logic signed [DATA_W-1:0] sample_b,
  input  logic                     next_lag,
  input  logic [LAG_W-1:0]         lag,
  output logic                     r_valid,
  output logic [LAG_W-1:0]         r_lag,
  output logic signed [ACC_W-1:0]  r_value,
  output logic                     ovf,
  output logic                     busy,
  output logic                     done,
  input  logic [IDX_W-1:0]         rd_addr,
  output logic signed [ACC_W-1:0]  rd_data
);

  // Add with clamp to the ACC_W signed range; hit flags a clamp.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic                    hit
  );
    logic signed [ACC_W:0] s;
    s   = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    hit = (s[ACC_W] != s[ACC_W-1]);
    if (!hit)
      return s[ACC_W-1:0];
    else if (s[ACC_W])
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  acc_state_t state;

  logic                     run;
  logic                     vld_p2;
  logic                     nl_p2;
  logic [LAG_W-1:0]         lag_p2;
  logic signed [2*DATA_W-1:0] prod_p2;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  addend;
  logic signed [ACC_W-1:0]  sum;
  logic                     sat_hit;

  logic signed [ACC_W-1:0]  bank [ORDER+1];

  // Pairs and closes only enter the pipe while a frame is running.
  assign run  = (state == RUN);
  assign busy = (state != IDLE);

  lpc_mac_pipe #(
    .DATA_W (DATA_W),
    .LAG_W  (LAG_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .mac_en   (mac_en & run),
    .next_lag (next_lag & run),
    .sample_a (sample_a),
    .sample_b (sample_b),
    .lag      (lag),
    .vld_p2   (vld_p2),
    .nl_p2    (nl_p2),
    .lag_p2   (lag_p2),
    .prod_p2  (prod_p2)
  );

  always_comb begin
    addend  = vld_p2 ? ACC_W'(prod_p2) : '0;
    sat_hit = 1'b0;
    sum     = sat_add(acc, addend, sat_hit);
  end

  // S3: accumulator, result strobe and frame FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      r_valid <= 1'b0;
      r_lag   <= '0;
      r_value <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      done    <= 1'b0;

      if (vld_p2 || nl_p2) begin
        if (sat_hit)
          ovf <= 1'b1;
        if (nl_p2) begin
          // Close: this cycle's product is included, next lag starts from 0.
          r_valid <= 1'b1;
          r_value <= sum;
          r_lag   <= lag_p2;
          acc     <= '0;
        end else begin
          acc <= sum;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            acc   <= '0;
            ovf   <= 1'b0;
          end
        end
        RUN: begin
          if (r_valid && r_lag == LAG_W'(ORDER)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result bank: lags beyond ORDER are strobed but not stored.
  always_ff @(posedge clk) begin
    if (r_valid && r_lag <= LAG_W'(ORDER))
      bank[r_lag[IDX_W-1:0]] <= r_value;
  end

  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_addr <= IDX_W'(ORDER))
      rd_data <= bank[rd_addr];
    else
      rd_data <= '0;
  end

endmodule
